// File: rtl/debounce_switches.sv
// Four-channel switch debouncer: each raw input is synchronized, then accepted
// only after holding a new level for DEBOUNCE_LIMIT consecutive cycles.
module debounce_switches #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  input  logic i_Switch_3,
  input  logic i_Switch_4,
  output logic o_Switch_1,
  output logic o_Switch_2,
  output logic o_Switch_3,
  output logic o_Switch_4,
  output logic o_Release_1,
  output logic o_Release_2,
  output logic o_Release_3,
  output logic o_Release_4
);

  localparam int CNT_W = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [3:0]       raw;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       state_q, state_d;
  logic [3:0]       release_q, release_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  // Per channel: counter only runs while the synchronized level disagrees with
  // the accepted level, so any bounce back to the accepted level restarts it.
  always_comb begin
    sync1_d   = raw;
    sync2_d   = sync1_q;
    state_d   = state_q;
    release_d = '0;
    for (int ch = 0; ch < 4; ch++) begin
      cnt_d[ch] = '0;
      if (sync2_q[ch] != state_q[ch]) begin
        if (cnt_q[ch] == CNT_MAX) begin
          state_d[ch]   = sync2_q[ch];
          release_d[ch] = ~sync2_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= '0;
      release_q <= '0;
      for (int ch = 0; ch < 4; ch++) cnt_q[ch] <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      release_q <= release_d;
      for (int ch = 0; ch < 4; ch++) cnt_q[ch] <= cnt_d[ch];
    end
  end

  assign o_Switch_1  = state_q[0];
  assign o_Switch_2  = state_q[1];
  assign o_Switch_3  = state_q[2];
  assign o_Switch_4  = state_q[3];
  assign o_Release_1 = release_q[0];
  assign o_Release_2 = release_q[1];
  assign o_Release_3 = release_q[2];
  assign o_Release_4 = release_q[3];

endmodule

// File: doc/debounce_switches.md
DEBOUNCE_SWITCHES -- requirements
Module: Debounce_Switches

Interface
REQ-001 The block SHALL have the parameter DEBOUNCE_LIMIT, default 250000 (10 ms at 25 MHz), giving the number of consecutive stable cycles required to accept a new switch level; legal range >= 2.
REQ-002 The block SHALL have these ports, clock and reset first:
- i_Clk  input  1  sole clock; all state updates on the rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Switch_1..i_Switch_4  input  1 each  raw, asynchronous mechanical switch levels; 1 = pressed.
- o_Switch_1..o_Switch_4  output  1 each  debounced switch levels; these drive the LED stage directly.
- o_Release_1..o_Release_4  output  1 each  one-cycle pulse on a debounced 1->0 transition.
REQ-003 The block SHALL use exactly one clock (i_Clk); reset (i_Reset) SHALL be synchronous and active-high.
REQ-004 Every output SHALL be driven directly from a register, with no combinational path from any input to any output.

Function
REQ-005 Each channel SHALL pass its i_Switch_n through a 2-flop synchronizer before any other logic uses it.
REQ-006 Each channel SHALL own an independent counter of width $clog2(DEBOUNCE_LIMIT) and a debounced-state register.
REQ-007 When the synchronized level equals the debounced state, the channel counter SHALL load 0 on the next edge.
REQ-008 When the synchronized level differs from the debounced state and the counter is below DEBOUNCE_LIMIT-1, the counter SHALL increment by 1.
REQ-009 When the synchronized level differs from the debounced state and the counter equals DEBOUNCE_LIMIT-1, the debounced state SHALL take the synchronized level and the counter SHALL load 0 on the same edge.
REQ-010 The counter SHALL never exceed DEBOUNCE_LIMIT-1 and SHALL never wrap.
REQ-011 Latency: when a raw level change is stable from rising edge k onward, o_Switch_n SHALL show the new level after edge k+DEBOUNCE_LIMIT+1, i.e. on the (DEBOUNCE_LIMIT+2)th edge counting edge k as the first.
REQ-012 A raw pulse or glitch lasting DEBOUNCE_LIMIT-1 cycles or fewer (after synchronization) SHALL leave o_Switch_n unchanged.
REQ-013 A raw level held for exactly DEBOUNCE_LIMIT synchronized cycles SHALL be accepted.
REQ-014 Any return of the synchronized level to the debounced state SHALL restart qualification from 0; counts SHALL NOT accumulate across bounces.
REQ-015 o_Release_n SHALL be 1 for exactly one cycle, registered on the same edge that o_Switch_n changes 1->0.
REQ-016 o_Release_n SHALL be 0 on every other cycle, including on 0->1 transitions.
REQ-017 The four channels SHALL operate independently; simultaneous transitions on any combination of channels SHALL each follow REQ-007..REQ-016 with no interaction.
REQ-018 The block SHALL contain no state other than the synchronizers, counters, debounced states and pulse registers.

Reset
REQ-019 While i_Reset=1 at a rising edge, all synchronizer flops, counters, debounced states, o_Switch_n and o_Release_n SHALL become 0 on that edge.
REQ-020 Reset asserted mid-qualification SHALL discard the partial count; no output transition and no release pulse SHALL result from reset itself.
REQ-021 After reset deassertion, a switch already held at 1 SHALL be re-qualified with the full REQ-011 latency, measured from the first edge with i_Reset=0.

Verification (DEBOUNCE_LIMIT=4 in simulation)
REQ-022 Reset with all raw inputs held at 1, then release at edge 0 -> outputs stay 0 through edge 4; o_Switch_1..4=1 after edge 5; o_Release all 0 throughout.
REQ-023 i_Switch_2 toggles every 2 cycles for 20 cycles, then holds 1 from edge k -> o_Switch_2 stays 0 throughout the bounce and goes 1 after edge k+5.
REQ-024 Stable-0 i_Switch_1 gets a 3-cycle high glitch -> o_Switch_1 remains 0; a 4-cycle high pulse -> o_Switch_1 becomes 1.
REQ-025 i_Switch_3 debounced at 1, raw drops to 0 at edge k -> o_Switch_3=0 and o_Release_3=1 after edge k+5, with o_Release_3=0 after edge k+6.
REQ-026 i_Switch_1 rises and i_Switch_4 falls on the same edge -> both outputs change after the same edge; only o_Release_4 pulses.
REQ-027 Reset asserted for 1 cycle while the i_Switch_2 counter=2 -> counter, state and outputs are 0; with raw still 1, o_Switch_2=1 five edges after reset deassertion.
